// File: rtl/pdm_cic_decim.sv
// Third-order CIC decimator turning a strobed 1-bit PDM stream into saturated signed PCM.
// Warm-up suppression hides the first three comb outputs after reset or clear.
module pdm_cic_decim #(
  parameter int C_DEC_LOG2 = 5,
  parameter int C_OUT_W    = 16
) (
  input  logic                      CK_i,
  input  logic                      XARST_i,
  input  logic                      EE_i,
  input  logic                      PDM_i,
  input  logic                      CLR_i,
  output logic signed [C_OUT_W-1:0] DATs_o,
  output logic                      VALID_o,
  output logic                      OVF_o
);

  localparam int W  = 3*C_DEC_LOG2 + 2;
  localparam int SH = 3*C_DEC_LOG2 - (C_OUT_W - 1);
  localparam logic [C_DEC_LOG2-1:0] CNT_MAX = '1;
  localparam logic signed [W-1:0]   OUT_MAX = W'((1 << (C_OUT_W-1)) - 1);
  localparam logic signed [W-1:0]   OUT_MIN = W'(-(1 << (C_OUT_W-1)));

  logic        [W-1:0]          i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic        [W-1:0]          d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic signed [W-1:0]          c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
  logic        [C_DEC_LOG2-1:0] cnt_q, cnt_d;
  logic                         v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic        [1:0]            warm_q, warm_d;
  logic signed [C_OUT_W-1:0]    dat_q, dat_d;
  logic                         valid_q, valid_d, ovf_q, ovf_d;
  logic        [W-1:0]          x_s;
  logic signed [W-1:0]          scaled_s;
  logic signed [C_OUT_W-1:0]    sat_s;
  logic                         clip_s;

  assign x_s = PDM_i ? W'(1) : '1;

  // Scale the comb result and clamp it into the output range.
  always_comb begin
    scaled_s = c3_q >>> SH;
    sat_s    = scaled_s[C_OUT_W-1:0];
    clip_s   = 1'b0;
    if (scaled_s > OUT_MAX) begin
      sat_s  = OUT_MAX[C_OUT_W-1:0];
      clip_s = 1'b1;
    end else if (scaled_s < OUT_MIN) begin
      sat_s  = OUT_MIN[C_OUT_W-1:0];
      clip_s = 1'b1;
    end else begin
      sat_s  = scaled_s[C_OUT_W-1:0];
      clip_s = 1'b0;
    end
  end

  // Next-state: integrators on strobes, comb stages on their valid flags, output stage last.
  always_comb begin
    i1_d = i1_q;  i2_d = i2_q;  i3_d = i3_q;
    d1_d = d1_q;  d2_d = d2_q;  d3_d = d3_q;
    c1_d = c1_q;  c2_d = c2_q;  c3_d = c3_q;
    cnt_d = cnt_q;
    v0_d = 1'b0;  v1_d = 1'b0;  v2_d = 1'b0;  v3_d = 1'b0;
    warm_d = warm_q;
    dat_d = dat_q;
    valid_d = 1'b0;
    ovf_d = ovf_q;
    if (CLR_i) begin
      // Clear drops the concurrent sample and cancels in-flight results; DATs_o keeps its value.
      i1_d = '0;  i2_d = '0;  i3_d = '0;
      d1_d = '0;  d2_d = '0;  d3_d = '0;
      c1_d = '0;  c2_d = '0;  c3_d = '0;
      cnt_d = '0;
      warm_d = 2'd0;
      ovf_d = 1'b0;
    end else begin
      if (EE_i) begin
        i1_d  = i1_q + x_s;
        i2_d  = i2_q + i1_d;
        i3_d  = i3_q + i2_d;
        cnt_d = cnt_q + C_DEC_LOG2'(1);
        v0_d  = (cnt_q == CNT_MAX);
      end else begin
        v0_d = 1'b0;
      end
      v1_d = v0_q;
      if (v0_q) begin
        c1_d = i3_q - d1_q;
        d1_d = i3_q;
      end else begin
        c1_d = c1_q;
      end
      v2_d = v1_q;
      if (v1_q) begin
        c2_d = c1_q - d2_q;
        d2_d = c1_q;
      end else begin
        c2_d = c2_q;
      end
      v3_d = v2_q;
      if (v2_q) begin
        c3_d = c2_q - d3_q;
        d3_d = c2_q;
      end else begin
        c3_d = c3_q;
      end
      if (v3_q) begin
        if (warm_q != 2'd3) begin
          warm_d = warm_q + 2'd1;
        end else begin
          valid_d = 1'b1;
          dat_d   = sat_s;
          ovf_d   = ovf_q | clip_s;
        end
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // State registers.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      i1_q <= '0;  i2_q <= '0;  i3_q <= '0;
      d1_q <= '0;  d2_q <= '0;  d3_q <= '0;
      c1_q <= '0;  c2_q <= '0;  c3_q <= '0;
      cnt_q <= '0;
      v0_q <= 1'b0;  v1_q <= 1'b0;  v2_q <= 1'b0;  v3_q <= 1'b0;
      warm_q <= 2'd0;
      dat_q <= '0;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      i1_q <= i1_d;  i2_q <= i2_d;  i3_q <= i3_d;
      d1_q <= d1_d;  d2_q <= d2_d;  d3_q <= d3_d;
      c1_q <= c1_d;  c2_q <= c2_d;  c3_q <= c3_d;
      cnt_q <= cnt_d;
      v0_q <= v0_d;  v1_q <= v1_d;  v2_q <= v2_d;  v3_q <= v3_d;
      warm_q <= warm_d;
      dat_q <= dat_d;
      valid_q <= valid_d;
      ovf_q <= ovf_d;
    end
  end

  assign DATs_o  = dat_q;
  assign VALID_o = valid_q;
  assign OVF_o   = ovf_q;

endmodule

// File: tb/tb_pdm_cic_decim.sv
// Bench for pdm_cic_decim: a direct-form triple boxcar model feeds a timestamped scoreboard.
module tb_pdm_cic_decim;

  localparam int  R     = 32;
  localparam int  OUT_W = 16;
  localparam int  SH    = 0;
  localparam time P     = 20;

  typedef struct {
    time t;
    int  dat;
    bit  ovf;
  } exp_t;

  logic                    CK = 1'b0;
  logic                    XARST_i = 1'b0;
  logic                    EE_i = 1'b0;
  logic                    PDM_i = 1'b0;
  logic                    CLR_i = 1'b0;
  logic signed [OUT_W-1:0] DATs_o;
  logic                    VALID_o;
  logic                    OVF_o;

  int   checks = 0;
  int   errors = 0;
  int   valid_seen = 0;
  int   last_dat = 0;
  int   ee_cnt = 0;
  int   warm = 0;
  int   feed_idx = 0;
  bit   ovf_m = 1'b0;
  int   xh[$];
  int   s1h[$];
  int   s2h[$];
  exp_t sb_q[$];

  pdm_cic_decim dut (
    .CK_i   (CK),
    .XARST_i(XARST_i),
    .EE_i   (EE_i),
    .PDM_i  (PDM_i),
    .CLR_i  (CLR_i),
    .DATs_o (DATs_o),
    .VALID_o(VALID_o),
    .OVF_o  (OVF_o)
  );

  always #(P/2) CK = ~CK;

  task automatic model_clear();
    xh.delete();
    s1h.delete();
    s2h.delete();
    sb_q.delete();
    ee_cnt = 0;
    warm   = 0;
    ovf_m  = 1'b0;
  endtask

  // Reference: three cascaded 32-tap moving sums, read out on every 32nd sample.
  task automatic model_sample(input logic pdm, input time t);
    int   s1, s2, s3, y, n;
    exp_t e;
    xh.push_back(pdm ? 1 : -1);
    n = xh.size();
    s1 = 0;
    for (int j = 0; j < R; j++) if (n - 1 - j >= 0) s1 += xh[n-1-j];
    s1h.push_back(s1);
    s2 = 0;
    for (int j = 0; j < R; j++) if (n - 1 - j >= 0) s2 += s1h[n-1-j];
    s2h.push_back(s2);
    s3 = 0;
    for (int j = 0; j < R; j++) if (n - 1 - j >= 0) s3 += s2h[n-1-j];
    ee_cnt++;
    if (ee_cnt == R) begin
      ee_cnt = 0;
      if (warm < 3) begin
        warm++;
      end else begin
        y = s3 >>> SH;
        if (y > 32767) begin
          y = 32767;
          ovf_m = 1'b1;
        end else if (y < -32768) begin
          y = -32768;
          ovf_m = 1'b1;
        end
        e.t   = t + 4*P + P/2;
        e.dat = y;
        e.ovf = ovf_m;
        sb_q.push_back(e);
      end
    end
  endtask

  // One clock: drive, update model at the edge, then check outputs at the falling edge.
  task automatic step(input logic ee, input logic pdm, input logic clr);
    exp_t e;
    EE_i  = ee;
    PDM_i = pdm;
    CLR_i = clr;
    @(posedge CK);
    if (XARST_i) begin
      if (clr) model_clear();
      else if (ee) model_sample(pdm, $time);
    end
    @(negedge CK);
    if (VALID_o) begin
      valid_seen++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: VALID_o=1 at %0t, expected no output", $time);
      end else begin
        e = sb_q.pop_front();
        if ($time !== e.t) begin
          errors++;
          $display("FAIL valid_latency: VALID_o at %0t, expected at %0t", $time, e.t);
        end
        checks++;
        if (int'(DATs_o) !== e.dat) begin
          errors++;
          $display("FAIL sample_value: DATs_o=%0d, expected %0d", DATs_o, e.dat);
        end
        checks++;
        if (OVF_o !== e.ovf) begin
          errors++;
          $display("FAIL ovf_at_valid: OVF_o=%0b, expected %0b", OVF_o, e.ovf);
        end
        last_dat = e.dat;
      end
    end
  endtask

  // mode: 0 const 0, 1 const 1, 2 pattern 1110, 3 pattern 10, 4 random; gap cycles toggle PDM.
  task automatic feed(input int n_ee, input int gap, input int mode);
    logic b;
    for (int k = 0; k < n_ee; k++) begin
      case (mode)
        0:       b = 1'b0;
        1:       b = 1'b1;
        2:       b = ((feed_idx % 4) != 3);
        3:       b = ((feed_idx % 2) == 0);
        default: b = 1'($urandom_range(0, 1));
      endcase
      feed_idx++;
      step(1'b1, b, 1'b0);
      for (int g = 1; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d expected samples never appeared, expected 0", name, sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic test_reset();
    XARST_i = 1'b0;
    model_clear();
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks += 3;
    if (DATs_o !== 16'sd0) begin errors++; $display("FAIL reset_dat: DATs_o=%0d, expected 0", DATs_o); end
    if (VALID_o !== 1'b0) begin errors++; $display("FAIL reset_valid: VALID_o=%0b, expected 0", VALID_o); end
    if (OVF_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: OVF_o=%0b, expected 0", OVF_o); end
    XARST_i = 1'b1;
    last_dat = 0;
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_const_one();
    int v0;
    v0 = valid_seen;
    feed(3*R, 12, 1);
    drain("const_one_warmup");
    checks++;
    if (valid_seen != v0) begin
      errors++;
      $display("FAIL const_one_warmup: %0d outputs in warm-up, expected 0", valid_seen - v0);
    end
    feed(3*R, 12, 1);
    drain("const_one");
    checks += 2;
    if (valid_seen - v0 != 3) begin
      errors++;
      $display("FAIL const_one_count: %0d outputs, expected 3", valid_seen - v0);
    end
    if (OVF_o !== 1'b1) begin errors++; $display("FAIL const_one_ovf: OVF_o=%0b, expected 1", OVF_o); end
  endtask

  task automatic test_pattern(input string name, input int mode);
    int v0;
    step(1'b0, 1'b0, 1'b1);
    v0 = valid_seen;
    feed(6*R, 3, mode);
    drain(name);
    checks += 2;
    if (valid_seen - v0 != 3) begin
      errors++;
      $display("FAIL %s_count: %0d outputs, expected 3", name, valid_seen - v0);
    end
    if (OVF_o !== ovf_m) begin errors++; $display("FAIL %s_ovf: OVF_o=%0b, expected %0b", name, OVF_o, ovf_m); end
  endtask

  task automatic test_spacing();
    step(1'b0, 1'b0, 1'b1);
    feed(7*R, 1, 4);
    drain("spacing1");
    step(1'b0, 1'b0, 1'b1);
    feed(6*R, 12, 4);
    drain("spacing12");
  endtask

  task automatic test_clr_mid();
    int v0;
    step(1'b0, 1'b0, 1'b1);
    feed(5*R, 2, 1);
    drain("clr_pre");
    feed(R-1, 2, 1);
    step(1'b1, 1'b1, 1'b1);
    v0 = valid_seen;
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0);
    checks += 3;
    if (valid_seen != v0) begin errors++; $display("FAIL clr_cancel: %0d outputs after clear, expected 0", valid_seen - v0); end
    if (OVF_o !== 1'b0) begin errors++; $display("FAIL clr_ovf: OVF_o=%0b, expected 0", OVF_o); end
    if (int'(DATs_o) !== last_dat) begin errors++; $display("FAIL clr_hold: DATs_o=%0d, expected %0d", DATs_o, last_dat); end
    feed(4*R, 2, 2);
    drain("clr_restart");
    checks++;
    if (valid_seen - v0 != 1) begin errors++; $display("FAIL clr_restart_count: %0d outputs, expected 1", valid_seen - v0); end
    // A clear two cycles after an event must cancel the in-flight result too.
    feed(R, 1, 2);
    step(1'b0, 1'b0, 1'b0);
    v0 = valid_seen;
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (valid_seen != v0) begin errors++; $display("FAIL clr_pending: %0d outputs after clear, expected 0", valid_seen - v0); end
  endtask

  task automatic test_async_reset();
    int v0;
    step(1'b0, 1'b0, 1'b1);
    feed(5*R, 2, 1);
    drain("arst_pre");
    feed(R-1, 2, 1);
    EE_i  = 1'b1;
    PDM_i = 1'b1;
    #3 XARST_i = 1'b0;
    model_clear();
    last_dat = 0;
    v0 = valid_seen;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
    checks += 2;
    if (DATs_o !== 16'sd0) begin errors++; $display("FAIL arst_dat: DATs_o=%0d, expected 0", DATs_o); end
    if (OVF_o !== 1'b0) begin errors++; $display("FAIL arst_ovf: OVF_o=%0b, expected 0", OVF_o); end
    XARST_i = 1'b1;
    feed(4*R, 2, 2);
    drain("arst_restart");
    checks++;
    if (valid_seen - v0 != 1) begin errors++; $display("FAIL arst_restart_count: %0d outputs, expected 1", valid_seen - v0); end
  endtask

  initial begin
    test_reset();
    test_const_one();
    test_pattern("const_zero", 0);
    test_pattern("pat_1110", 2);
    test_pattern("pat_10", 3);
    test_spacing();
    test_clr_mid();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
